// File: rtl/regfile_writeback_pkg.sv
// Shared definitions for the register-file write-back front end:
// default widths, the zero register and the arbiter state encoding.
package regfile_writeback_pkg;

    localparam int unsigned DefaultDataWidth = 32;
    localparam int unsigned DefaultAddrWidth = 5;
    localparam int unsigned StarveCntW       = 4;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic {
        AluPri = 1'b0,
        MemPri = 1'b1
    } arb_state_e;

endpackage

// File: rtl/writeback_scoreboard.sv
// Pending-write scoreboard: one busy bit per register. A bit is set on issue and
// cleared on write-back; when both happen on the same edge, the set wins.
module writeback_scoreboard #(
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       set_en_i,
    input  logic [ADDR_WIDTH-1:0]      set_addr_i,
    input  logic                       clr_en_i,
    input  logic [ADDR_WIDTH-1:0]      clr_addr_i,
    output logic                       stall_o,
    output logic [2**ADDR_WIDTH-1:0]   busy_o
);

    logic [2**ADDR_WIDTH-1:0] busy_q, busy_d;

    // set_en_i is the issue request; it only takes effect when not stalled.
    assign stall_o = set_en_i && (set_addr_i != '0) && busy_q[set_addr_i];

    always_comb begin
        busy_d = busy_q;
        if (clr_en_i) begin
            busy_d[clr_addr_i] = 1'b0;
        end
        if (set_en_i && !stall_o) begin
            busy_d[set_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/regfile_writeback.sv
// Arbitrates ALU and load results onto the register file's single write port,
// with starvation protection for loads and a pending-write scoreboard.
module regfile_writeback
    import regfile_writeback_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DefaultDataWidth,
    parameter int unsigned ADDR_WIDTH   = DefaultAddrWidth,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                      CLOCK,
    input  logic                      RESET,
    input  logic                      ALU_VALID,
    output logic                      ALU_READY,
    input  logic [ADDR_WIDTH-1:0]     ALU_DEST,
    input  logic [DATA_WIDTH-1:0]     ALU_DATA,
    input  logic                      MEM_VALID,
    output logic                      MEM_READY,
    input  logic [ADDR_WIDTH-1:0]     MEM_DEST,
    input  logic [DATA_WIDTH-1:0]     MEM_DATA,
    input  logic                      ISSUE_VALID,
    input  logic [ADDR_WIDTH-1:0]     ISSUE_DEST,
    output logic                      STALL,
    output logic [2**ADDR_WIDTH-1:0]  BUSY,
    output logic [ADDR_WIDTH-1:0]     A3,
    output logic                      WE,
    output logic [DATA_WIDTH-1:0]     WD
);

    localparam logic [StarveCntW-1:0] StarveMax = StarveCntW'(STARVE_LIMIT);
    localparam logic [ADDR_WIDTH-1:0] RegZero   = ADDR_WIDTH'(REG_ZERO);

    arb_state_e              state_q, state_d;
    logic [StarveCntW-1:0]   starve_q, starve_d;
    logic [ADDR_WIDTH-1:0]   a3_q, a3_d;
    logic [DATA_WIDTH-1:0]   wd_q, wd_d;
    logic                    we_q, we_d;

    logic                    alu_xfer, mem_xfer, xfer;
    logic [ADDR_WIDTH-1:0]   xfer_dest;
    logic [DATA_WIDTH-1:0]   xfer_data;

    always_comb begin
        ALU_READY = 1'b1;
        MEM_READY = !ALU_VALID;
        if (state_q == MemPri) begin
            MEM_READY = 1'b1;
            ALU_READY = !MEM_VALID;
        end

        // Ready functions guarantee at most one of these is high.
        alu_xfer  = ALU_VALID && ALU_READY;
        mem_xfer  = MEM_VALID && MEM_READY;
        xfer      = alu_xfer || mem_xfer;
        xfer_dest = alu_xfer ? ALU_DEST : MEM_DEST;
        xfer_data = alu_xfer ? ALU_DATA : MEM_DATA;

        a3_d = a3_q;
        wd_d = wd_q;
        we_d = 1'b0;
        if (xfer) begin
            a3_d = xfer_dest;
            wd_d = xfer_data;
            we_d = (xfer_dest != RegZero);
        end

        starve_d = '0;
        if (MEM_VALID && !MEM_READY) begin
            starve_d = (starve_q == StarveMax) ? starve_q : starve_q + 1'b1;
        end

        state_d = state_q;
        unique case (state_q)
            AluPri: if (starve_d == StarveMax) state_d = MemPri;
            MemPri: if (mem_xfer || !MEM_VALID) state_d = AluPri;
            default: state_d = AluPri;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q  <= AluPri;
            starve_q <= '0;
            a3_q     <= '0;
            wd_q     <= '0;
            we_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            a3_q     <= a3_d;
            wd_q     <= wd_d;
            we_q     <= we_d;
        end
    end

    assign A3 = a3_q;
    assign WD = wd_q;
    assign WE = we_q;

    writeback_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_scoreboard (
        .clk_i      (CLOCK),
        .rst_i      (RESET),
        .set_en_i   (ISSUE_VALID),
        .set_addr_i (ISSUE_DEST),
        .clr_en_i   (xfer),
        .clr_addr_i (xfer_dest),
        .stall_o    (STALL),
        .busy_o     (BUSY)
    );

endmodule
